// File: rtl/circ_q_pkg.sv
`default_nettype none
// ============================================================================
// Module      : circ_q_pkg
// Description : Shared types and helpers for the circular sample queue.
//               Provides the burst FSM state encoding and a wrap-around
//               pointer increment for rings whose depth need not be a
//               power of two.
// Revision    : 1.0 - initial release
// ============================================================================
package circ_q_pkg;

    // Burst FSM: idle, RAM prefetch, replay
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2
    } q_state_t;

    // Increment a ring pointer, wrapping from depth-1 back to 0
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr,
                                             input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/circ_smpl_queue_ram.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_ram
// Description : Simple dual-port RAM, one write port and one read port on a
//               single clock. Synchronous write, synchronous read with one
//               cycle of latency. Holds all queue channels packed per word.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1536,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Registered write and registered read; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/circ_smpl_queue.sv
`default_nettype none
// ============================================================================
// Module      : circ_smpl_queue
// Description : Circular sample queue for the audio filter path. Stores every
//               multi-channel input sample in a DEPTH-entry ring; once FILL
//               samples are resident, each new sample launches a burst that
//               replays the SEQ_LEN oldest samples, one per clock.
//               Optional feature macro: QUEUE_OVR_DET_EN (sticky missed-
//               trigger flag on ovr; tied low when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module circ_smpl_queue
    import circ_q_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 1536,
    parameter int FILL    = 1531,
    parameter int SEQ_LEN = 1021
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrt_smpl,
    input  logic [NUM_CH*DATA_W-1:0] smpl_in,
    output logic [NUM_CH*DATA_W-1:0] smpl_out,
    output logic                     sequencing,
    output logic                     seq_done,
    output logic                     ovr
);

    localparam int                c_smpl_w   = NUM_CH * DATA_W;
    localparam int                c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_cnt_w    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [31:0]       c_depth    = 32'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_fill_ptr = c_ptr_w'(FILL);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SEQ_LEN - 1);

    q_state_t            r_state;
    q_state_t            w_state_nxt;
    logic [c_ptr_w-1:0]  r_new_ptr;
    logic [c_ptr_w-1:0]  r_old_ptr;
    logic [c_ptr_w-1:0]  r_start_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_full;
    logic                w_trigger;
    logic [c_ptr_w-1:0]  w_new_ptr_inc;
    logic [c_ptr_w-1:0]  w_old_ptr_inc;
    logic [c_ptr_w-1:0]  w_rd_ptr_inc;
    logic [c_ptr_w-1:0]  w_raddr;
    logic [c_smpl_w-1:0] w_rdata;

    assign w_new_ptr_inc = c_ptr_w'(wrap_inc(32'(r_new_ptr), c_depth));
    assign w_old_ptr_inc = c_ptr_w'(wrap_inc(32'(r_old_ptr), c_depth));
    assign w_rd_ptr_inc  = c_ptr_w'(wrap_inc(32'(r_rd_ptr),  c_depth));

    // A burst only launches from IDLE; triggers while busy are lost
    assign w_trigger = wrt_smpl && r_full && (r_state == IDLE);

    // The prefetch cycle addresses the captured start; the replay walks rd_ptr,
    // which is already one ahead so the 1-cycle RAM latency is hidden
    assign w_raddr = (r_state == WAIT) ? r_start_ptr : r_rd_ptr;

    dual_port_ram #(
        .WIDTH  (c_smpl_w),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ptr_w)
    ) u_ram (
        .clk   (clk),
        .we    (wrt_smpl),
        .waddr (r_new_ptr),
        .raddr (w_raddr),
        .wdata (smpl_in),
        .rdata (w_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and burst status outputs
    always_comb begin
        w_state_nxt = r_state;
        sequencing  = 1'b0;
        seq_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_state_nxt = READ;
            end
            READ: begin
                sequencing = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    seq_done    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Ring pointers, fill flag, burst window capture and replay counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_ptr   <= '0;
            r_old_ptr   <= '0;
            r_start_ptr <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_full      <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                r_new_ptr <= w_new_ptr_inc;
                if (r_full) begin
                    r_old_ptr <= w_old_ptr_inc;
                end
            end
            if (r_new_ptr == c_fill_ptr) begin
                r_full <= 1'b1;
            end
            if (w_trigger) begin
                r_start_ptr <= r_old_ptr;
                r_rd_ptr    <= r_old_ptr;
                r_cnt       <= '0;
            end else if (r_state == WAIT || r_state == READ) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (r_state == READ) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Gate the RAM output so the sample bus reads zero outside a burst
    assign smpl_out = sequencing ? w_rdata : '0;

`ifdef QUEUE_OVR_DET_EN
    logic r_ovr;

    // Sticky flag: a full-queue write arrived while a burst was in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (wrt_smpl && r_full && (r_state != IDLE)) begin
            r_ovr <= 1'b1;
        end
    end

    assign ovr = r_ovr;
`else
    assign ovr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_circ_smpl_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_circ_smpl_queue
// Description : Directed self-checking bench for circ_smpl_queue. A small
//               instance (DEPTH=16, FILL=12, SEQ_LEN=8) covers fill, burst
//               content, ring wrap, missed triggers and mid-burst reset; a
//               default-parameter instance covers the full-size burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circ_smpl_queue;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        wr_s  = 1'b0;
    logic [31:0] in_s  = '0;
    logic [31:0] out_s;
    logic        seq_s, done_s, ovr_s;

    logic        wr_b  = 1'b0;
    logic [31:0] in_b  = '0;
    logic [31:0] out_b;
    logic        seq_b, done_b, ovr_b;

    int tests = 0;
    int fails = 0;
    int nval  = 0;

    always #5 clk = ~clk;

    circ_smpl_queue #(
        .DATA_W(16), .NUM_CH(2), .DEPTH(16), .FILL(12), .SEQ_LEN(8)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(wr_s), .smpl_in(in_s),
        .smpl_out(out_s), .sequencing(seq_s), .seq_done(done_s), .ovr(ovr_s)
    );

    circ_smpl_queue u_big (
        .clk(clk), .rst_n(rst_n), .wrt_smpl(wr_b), .smpl_in(in_b),
        .smpl_out(out_b), .sequencing(seq_b), .seq_done(done_b), .ovr(ovr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input int v);
        return {16'(v + 100), 16'(v)};
    endfunction

    // One-cycle write of the next sequential value to the small queue
    task automatic wr_small();
        in_s = pack(nval);
        wr_s = 1'b1;
        step();
        wr_s = 1'b0;
        nval++;
    endtask

    // Idle for n cycles and confirm no burst appears
    task automatic no_burst(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (seq_s) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    // Called in the cycle after the trigger (prefetch). Checks the 8-sample
    // replay starting at value 'first'; optionally injects a write at k==inj.
    task automatic burst_small(input int first, input int inj);
        chk("prefetch_seq", 32'(seq_s), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            if (wr_s) begin
                wr_s = 1'b0;
                nval++;
            end
            chk("burst_seq",  32'(seq_s),  32'd1);
            chk("burst_data", out_s,       pack(first + k));
            chk("burst_done", 32'(done_s), (k == 7) ? 32'd1 : 32'd0);
            if (k == inj) begin
                in_s = pack(nval);
                wr_s = 1'b1;
            end
        end
        step();
        chk("burst_end", 32'(seq_s), 32'd0);
    endtask

    initial begin
        int trig;
        int dcnt;
        int dlast;
        logic [31:0] ovr_exp;
`ifdef QUEUE_OVR_DET_EN
        ovr_exp = 32'd1;
`else
        ovr_exp = 32'd0;
`endif

        // Reset state
        repeat (3) step();
        chk("rst_seq",  32'(seq_s),  32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_ovr",  32'(ovr_s),  32'd0);
        chk("rst_out",  out_s,       32'd0);
        chk("rst_seq_big", 32'(seq_b), 32'd0);
        rst_n = 1'b1;
        step();

        // Fill with values 0..11: queue becomes full, no burst yet
        for (int i = 0; i < 12; i++) begin
            wr_small();
            step();
        end
        no_burst("fill_no_burst", 12);

        // Triggers 12..21 spaced 12 cycles; 16 yields 4..11, 21 wraps 15->0
        for (int n = 12; n < 22; n++) begin
            trig = nval;
            wr_small();
            burst_small(trig - 12, -1);
            repeat (2) step();
        end
        chk("ovr_quiet", 32'(ovr_s), 32'd0);

        // Trigger 22, then a write 3 cycles into the burst (value 23)
        trig = nval;
        wr_small();
        burst_small(trig - 12, 2);
        no_burst("missed_no_burst", 10);
        chk("ovr_missed", 32'(ovr_s), ovr_exp);

        // Later bursts stay contiguous; trigger 28 replays 16..23 incl. 23
        for (int n = 0; n < 5; n++) begin
            trig = nval;
            wr_small();
            burst_small(trig - 12, -1);
            repeat (2) step();
        end

        // Reset mid-READ: outputs drop at once
        wr_small();
        repeat (3) step();
        chk("pre_rst_seq", 32'(seq_s), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_seq",  32'(seq_s),  32'd0);
        chk("midrst_done", 32'(done_s), 32'd0);
        chk("midrst_out",  out_s,       32'd0);
        chk("midrst_ovr",  32'(ovr_s),  32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Refill from scratch: no burst until FILL new writes
        nval = 300;
        for (int i = 0; i < 12; i++) begin
            wr_small();
            step();
        end
        no_burst("refill_no_burst", 12);
        trig = nval;
        wr_small();
        burst_small(trig - 12, -1);

        // Default-size instance: fill 1531, trigger, 1021-sample replay
        for (int i = 0; i < 1531; i++) begin
            in_b = pack(i);
            wr_b = 1'b1;
            step();
        end
        wr_b = 1'b0;
        step();
        chk("big_no_burst", 32'(seq_b), 32'd0);
        in_b = pack(1531);
        wr_b = 1'b1;
        step();
        wr_b = 1'b0;
        chk("big_prefetch", 32'(seq_b), 32'd0);
        dcnt  = 0;
        dlast = -1;
        for (int k = 0; k < 1021; k++) begin
            step();
            chk("big_seq",  32'(seq_b), 32'd1);
            chk("big_data", out_b,      pack(k));
            if (done_b) begin
                dcnt++;
                dlast = k;
            end
        end
        chk("big_done_cnt",  32'(dcnt),  32'd1);
        chk("big_done_last", 32'(dlast), 32'd1020);
        step();
        chk("big_end", 32'(seq_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
